udcntn: RTL

Parametrised synchronous up/down counter with parallel load, auto-reload register, terminal-count pulse and a cascadable carry chain. It is the multi-bit, generalised successor of the single-bit `udcnt` slice used in TOM's timer and address-generation logic. It provides the per-bit behaviour of a `udcnt` chain at any width in one block. On top of that it adds auto-reload and a registered terminal-count pulse for timer use.

---
 rtl/udcntn.sv | 106 ++++++++++
 1 files changed

// File: rtl/udcntn.sv
`default_nettype none
// ============================================================================
// Module      : udcntn
// Description : Parametrised synchronous up/down counter with parallel load,
//               auto-reload register, registered terminal-count pulse and a
//               combinational carry chain for cascading instances.
//
//               Optional feature macro: UDCNTN_SATURATE_EN
//                 defined   -> a terminal event with auto=0 holds q at the
//                              terminal value instead of wrapping.
//                 undefined -> a terminal event with auto=0 wraps modulo
//                              2^WIDTH.
//
// Parameters  : WIDTH   - counter width in bits (2..32)
//               RST_VAL - value loaded into q on reset
//
// Ports       : sys_clk - clock, rising edge
//               resetl  - synchronous active-low reset
//               ci      - count enable / carry in from previous stage
//               up      - direction, 1 = increment, 0 = decrement
//               ld      - parallel load of d into q (overrides ci)
//               d       - parallel load value
//               rld_we  - reload register write strobe
//               rld     - reload register write data
//               auto    - auto-reload mode select
//               q       - counter value
//               co      - combinational carry out (ci & q at terminal)
//               tc      - registered terminal-count pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module udcntn #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             ci,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             rld_we,
    input  logic [WIDTH-1:0] rld,
    input  logic             auto,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             tc
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rld_q;
    logic             r_tc;

    logic [WIDTH-1:0] w_term;
    logic             w_at_term;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc_nxt;

    // Terminal value follows the current direction, so a direction change
    // re-targets the terminal comparison in the same cycle.
    assign w_term    = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign w_at_term = (r_q == w_term);

    always_comb begin
        w_q_nxt  = r_q;
        w_tc_nxt = 1'b0;
        if (ld) begin
            w_q_nxt = d;
        end else if (ci && !w_at_term) begin
            w_q_nxt = up ? (r_q + 1'b1) : (r_q - 1'b1);
        end else if (ci) begin
            // Terminal event. Reload uses the register's current contents,
            // so a write in this same cycle only affects the next event.
            w_tc_nxt = 1'b1;
            if (auto) begin
                w_q_nxt = r_rld_q;
            end else begin
`ifdef UDCNTN_SATURATE_EN
                w_q_nxt = r_q;
`else
                w_q_nxt = up ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
`endif
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            r_q     <= RST_VAL;
            r_rld_q <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_tc <= w_tc_nxt;
            if (rld_we) begin
                r_rld_q <= rld;
            end
        end
    end

    assign q  = r_q;
    assign tc = r_tc;
    assign co = ci & w_at_term;

endmodule
`default_nettype wire
